// File: rtl/equation_sweep_checker_if.sv
// Bundle of the stimulus/response and status signals of equation_sweep_checker.
// master: the checker side. slave: the environment driving start and the two
// equation outputs.
interface equation_sweep_checker_if;
    logic       start;
    logic       A;
    logic       B;
    logic       C;
    logic       D;
    logic       ref_out;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic [3:0] first_fail;
    logic       fail_valid;

    modport master (
        input  start, ref_out, dut_out,
        output A, B, C, D, busy, done, pass, err_count, first_fail, fail_valid
    );

    modport slave (
        output start, ref_out, dut_out,
        input  A, B, C, D, busy, done, pass, err_count, first_fail, fail_valid
    );
endinterface

// File: rtl/equation_sweep_checker.sv
// Exhaustive 4-input equation checker: sweeps {A,B,C,D} over 0..15, holds each
// vector SETTLE cycles, then compares ref_out against dut_out for one cycle.
// Optional macro SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module equation_sweep_checker #(
    parameter int unsigned SETTLE = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    equation_sweep_checker_if.master   bus_io
);

    typedef enum logic [1:0] {StIdle, StHold, StCheck, StDone} state_e;

    // With SETTLE = 0 the hold phase is skipped entirely.
    localparam state_e     StFirst    = (SETTLE == 0) ? StCheck : StHold;
    localparam logic [2:0] SettleLast = (SETTLE == 0) ? 3'd0 : 3'(SETTLE - 1);

    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [2:0] cnt_q, cnt_d;
    logic [4:0] err_q, err_d;
    logic [3:0] ff_q, ff_d;
    logic       fv_q, fv_d;
    logic       mismatch;
    logic       stop_now;
    logic       active;

    assign mismatch = bus_io.ref_out ^ bus_io.dut_out;
    assign active   = (state_q == StHold) || (state_q == StCheck);

    // State and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= 4'd0;
            cnt_q   <= 3'd0;
            err_q   <= 5'd0;
            ff_q    <= 4'hF;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            fv_q    <= fv_d;
        end
    end

    // Next-state logic: start acceptance, settle counting, compare and advance.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        ff_d     = ff_q;
        fv_d     = fv_q;
        stop_now = (idx_q == 4'hF);
`ifdef SWEEP_STOP_ON_FAIL_EN
        stop_now = stop_now | mismatch;
`endif
        case (state_q)
            StIdle, StDone: begin
                if (bus_io.start) begin
                    state_d = StFirst;
                    idx_d   = 4'd0;
                    cnt_d   = 3'd0;
                    err_d   = 5'd0;
                    ff_d    = 4'hF;
                    fv_d    = 1'b0;
                end
            end
            StHold: begin
                if (cnt_q == SettleLast) begin
                    state_d = StCheck;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    // 16 vectors can never exceed 16 errors, but never wrap regardless.
                    err_d = (err_q == 5'd16) ? err_q : err_q + 5'd1;
                    if (!fv_q) begin
                        ff_d = idx_q;
                        fv_d = 1'b1;
                    end
                end
                if (stop_now) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = 3'd0;
                    state_d = StFirst;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state; vector is forced to zero outside a sweep.
    always_comb begin
        bus_io.A          = active & idx_q[3];
        bus_io.B          = active & idx_q[2];
        bus_io.C          = active & idx_q[1];
        bus_io.D          = active & idx_q[0];
        bus_io.busy       = active;
        bus_io.done       = (state_q == StDone);
        bus_io.pass       = (state_q == StDone) && (err_q == 5'd0);
        bus_io.err_count  = err_q;
        bus_io.first_fail = ff_q;
        bus_io.fail_valid = fv_q;
    end

endmodule

// File: tb/tb_equation_sweep_checker.sv
// Directed bench for equation_sweep_checker: one instance with SETTLE=1 and one
// with SETTLE=0, driven by small equation models selected by 'mode'.
module tb_equation_sweep_checker;

    logic clk = 1'b0;
    logic reset;
    int   mode;
    int   tests;
    int   fails;

    always #5 clk = ~clk;

    equation_sweep_checker_if if1 ();
    equation_sweep_checker_if if0 ();

    equation_sweep_checker #(.SETTLE(1)) u_dut1 (
        .clk    (clk),
        .reset  (reset),
        .bus_io (if1.master)
    );

    equation_sweep_checker #(.SETTLE(0)) u_dut0 (
        .clk    (clk),
        .reset  (reset),
        .bus_io (if0.master)
    );

    // mode 0: equal outputs; 1: ref=~B, dut=C|~B (differ only at B=1,C=1);
    // 2: ref=0, dut=C (differ wherever C=1); 3: ref=0, dut=1 (all differ).
    function automatic logic ref_fn(input int m, input logic [3:0] v);
        case (m)
            0:       ref_fn = v[3] ^ v[0];
            1:       ref_fn = ~v[2];
            default: ref_fn = 1'b0;
        endcase
    endfunction

    function automatic logic dut_fn(input int m, input logic [3:0] v);
        case (m)
            0:       dut_fn = v[3] ^ v[0];
            1:       dut_fn = v[1] | ~v[2];
            2:       dut_fn = v[1];
            default: dut_fn = 1'b1;
        endcase
    endfunction

    assign if1.ref_out = ref_fn(mode, {if1.A, if1.B, if1.C, if1.D});
    assign if1.dut_out = dut_fn(mode, {if1.A, if1.B, if1.C, if1.D});
    assign if0.ref_out = ref_fn(mode, {if0.A, if0.B, if0.C, if0.D});
    assign if0.dut_out = dut_fn(mode, {if0.A, if0.B, if0.C, if0.D});

    // Expected results per mode.
    int         exp_cyc [4];
    int         exp_err [4];
    logic [3:0] exp_ff  [4];

    task automatic test_reset();
        if ({if1.busy, if1.done, if1.pass, if1.fail_valid} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags1 got %b want 0000",
                     {if1.busy, if1.done, if1.pass, if1.fail_valid});
        end
        tests++;
        if ({if1.err_count, if1.first_fail} !== {5'd0, 4'hF}) begin
            fails++;
            $display("FAIL reset_counts1 got err=%0d ff=%h want err=0 ff=f",
                     if1.err_count, if1.first_fail);
        end
        tests++;
        if ({if1.A, if1.B, if1.C, if1.D} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_vec1 got %b want 0000", {if1.A, if1.B, if1.C, if1.D});
        end
        tests++;
        if ({if0.busy, if0.done, if0.pass, if0.fail_valid, if0.err_count, if0.first_fail}
            !== {4'b0000, 5'd0, 4'hF}) begin
            fails++;
            $display("FAIL reset_all0 got busy=%b done=%b pass=%b fv=%b err=%0d ff=%h",
                     if0.busy, if0.done, if0.pass, if0.fail_valid, if0.err_count,
                     if0.first_fail);
        end
        tests++;
    endtask

    // Pulse start on the SETTLE=1 instance and count busy cycles, checking the
    // applied vector each cycle (index advances every two cycles).
    task automatic run1(input int m, output int cycles, output int vbad);
        logic [3:0] want;
        mode   = m;
        cycles = 0;
        vbad   = 0;
        @(negedge clk);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        while (if1.busy === 1'b1 && cycles < 200) begin
            cycles++;
            want = 4'((cycles - 1) / 2);
            if ({if1.A, if1.B, if1.C, if1.D} !== want) vbad++;
            @(negedge clk);
        end
    endtask

    task automatic test_sweeps();
        int cyc;
        int vbad;
        for (int m = 0; m < 4; m++) begin
            run1(m, cyc, vbad);
            if (cyc !== exp_cyc[m]) begin
                fails++;
                $display("FAIL sweep%0d_cycles got %0d want %0d", m, cyc, exp_cyc[m]);
            end
            tests++;
            if (vbad !== 0) begin
                fails++;
                $display("FAIL sweep%0d_vectors got %0d bad cycles want 0", m, vbad);
            end
            tests++;
            if ({if1.done, if1.busy} !== 2'b10) begin
                fails++;
                $display("FAIL sweep%0d_done got done=%b busy=%b want 1/0",
                         m, if1.done, if1.busy);
            end
            tests++;
            if (if1.err_count !== 5'(exp_err[m])) begin
                fails++;
                $display("FAIL sweep%0d_err got %0d want %0d", m, if1.err_count, exp_err[m]);
            end
            tests++;
            if (if1.first_fail !== exp_ff[m]) begin
                fails++;
                $display("FAIL sweep%0d_first_fail got %h want %h", m, if1.first_fail,
                         exp_ff[m]);
            end
            tests++;
            if ({if1.fail_valid, if1.pass} !== {exp_err[m] != 0, exp_err[m] == 0}) begin
                fails++;
                $display("FAIL sweep%0d_pass got fv=%b pass=%b want fv=%b pass=%b", m,
                         if1.fail_valid, if1.pass, exp_err[m] != 0, exp_err[m] == 0);
            end
            tests++;
            if ({if1.A, if1.B, if1.C, if1.D} !== 4'b0000) begin
                fails++;
                $display("FAIL sweep%0d_vec_done got %b want 0000", m,
                         {if1.A, if1.B, if1.C, if1.D});
            end
            tests++;
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        mode = 3;
        @(negedge clk);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        if ({if1.busy, if1.done, if1.pass, if1.fail_valid, if1.A, if1.B, if1.C, if1.D,
             if1.err_count, if1.first_fail} !== {8'b0, 5'd0, 4'hF}) begin
            fails++;
            $display("FAIL reset_async got busy=%b done=%b fv=%b vec=%b err=%0d ff=%h",
                     if1.busy, if1.done, if1.fail_valid, {if1.A, if1.B, if1.C, if1.D},
                     if1.err_count, if1.first_fail);
        end
        tests++;
        // Release reset and request a sweep for the very first edge afterwards.
        mode = 0;
        @(negedge clk);
        reset     = 1'b0;
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        if (if1.busy !== 1'b1) begin
            fails++;
            $display("FAIL first_start got busy=%b want 1", if1.busy);
        end
        tests++;
        cyc = 0;
        while (if1.busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc !== 32) begin
            fails++;
            $display("FAIL post_reset_cycles got %0d want 32", cyc);
        end
        tests++;
        if ({if1.done, if1.pass, if1.err_count, if1.fail_valid, if1.first_fail}
            !== {2'b11, 5'd0, 1'b0, 4'hF}) begin
            fails++;
            $display("FAIL post_reset_result got done=%b pass=%b err=%0d fv=%b ff=%h",
                     if1.done, if1.pass, if1.err_count, if1.fail_valid, if1.first_fail);
        end
        tests++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        int vbad;
        mode = 0;
        vbad = 0;
        @(negedge clk);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        cyc = 0;
        while (if0.busy === 1'b1 && cyc < 200) begin
            cyc++;
            if ({if0.A, if0.B, if0.C, if0.D} !== 4'(cyc - 1)) vbad++;
            // Restart attempts mid-sweep and during the final CHECK.
            if0.start = (cyc == 3 || cyc == 16);
            @(negedge clk);
        end
        if0.start = 1'b0;
        if (cyc !== 16) begin
            fails++;
            $display("FAIL settle0_cycles got %0d want 16", cyc);
        end
        tests++;
        if (vbad !== 0) begin
            fails++;
            $display("FAIL settle0_vectors got %0d bad cycles want 0", vbad);
        end
        tests++;
        @(negedge clk);
        if ({if0.done, if0.busy, if0.pass} !== 3'b101) begin
            fails++;
            $display("FAIL settle0_held got done=%b busy=%b pass=%b want 1/0/1",
                     if0.done, if0.busy, if0.pass);
        end
        tests++;
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        if ({if0.done, if0.busy} !== 2'b01) begin
            fails++;
            $display("FAIL settle0_restart got done=%b busy=%b want 0/1", if0.done, if0.busy);
        end
        tests++;
        cyc = 0;
        while (if0.busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        if ({if0.done, if0.pass, 32'(cyc)} !== {2'b11, 32'd16}) begin
            fails++;
            $display("FAIL settle0_second got done=%b pass=%b cycles=%0d want 1/1/16",
                     if0.done, if0.pass, cyc);
        end
        tests++;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        mode      = 0;
        reset     = 1'b1;
        if1.start = 1'b0;
        if0.start = 1'b0;
`ifdef SWEEP_STOP_ON_FAIL_EN
        exp_cyc = '{32, 14, 6, 2};
        exp_err = '{0, 1, 1, 1};
`else
        exp_cyc = '{32, 32, 32, 32};
        exp_err = '{0, 4, 8, 16};
`endif
        exp_ff  = '{4'hF, 4'h6, 4'h2, 4'h0};
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_sweeps();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
